// File: rtl/ld_rs_pkg.sv
// ld_rs_pkg: shared opcodes, widths, operand type and CDB capture helper for the load RS
package ld_rs_pkg;
    localparam int TAG_W = 6;
    localparam int DATA_W = 16;
    localparam logic [3:0] LD = 4'd4;
    localparam logic [3:0] LDR = 4'd5;
    typedef struct packed {
        logic              rdy;
        logic [DATA_W-1:0] val;
    } src_t;
    function automatic src_t capture(
        input src_t              s,
        input logic              a_v,
        input logic [TAG_W-1:0]  a_tag,
        input logic [DATA_W-1:0] a_res,
        input logic              b_v,
        input logic [TAG_W-1:0]  b_tag,
        input logic [DATA_W-1:0] b_res
    );
        logic a_hit, b_hit;
        a_hit = !s.rdy && a_v && a_tag == s.val[TAG_W-1:0];
        b_hit = !s.rdy && b_v && b_tag == s.val[TAG_W-1:0];
        return a_hit ? src_t'({1'b1, a_res}) : b_hit ? src_t'({1'b1, b_res}) : s;
    endfunction
endpackage

`define RS_TAG(i) (RS_BASE + TAG_W'(i))

// File: rtl/ld_rs_pick.sv
// ld_rs_pick: one-hot oldest-ready picker driven by an age matrix
module ld_rs_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0] rdy_i,
    input  logic [N-1:0] older_i [N],
    output logic [N-1:0] gnt_o,
    output logic         any_o
);
    for (genvar i = 0; i < N; i++) begin : g_pick
        assign gnt_o[i] = rdy_i[i] && !(|(rdy_i & older_i[i]));
    end
    assign any_o = |rdy_i;
endmodule

// File: rtl/ld_rs.sv
// ld_rs: load reservation station with dual-CDB wakeup and oldest-ready issue to the LD unit
module ld_rs
    import ld_rs_pkg::*;
#(
    parameter int               N       = 4,
    parameter logic [TAG_W-1:0] RS_BASE = 6'd8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              disp_valid,
    input  logic [3:0]        disp_op,
    input  logic [DATA_W-1:0] disp_pc,
    input  logic              disp_rdy0,
    input  logic [DATA_W-1:0] disp_val0,
    input  logic              disp_rdy1,
    input  logic [DATA_W-1:0] disp_val1,
    output logic [TAG_W-1:0]  disp_tag,
    output logic              full,
    input  logic              cdbA_valid,
    input  logic [TAG_W-1:0]  cdbA_rs_num,
    input  logic [DATA_W-1:0] cdbA_res,
    input  logic              cdbB_valid,
    input  logic [TAG_W-1:0]  cdbB_rs_num,
    input  logic [DATA_W-1:0] cdbB_res,
    output logic              iss_valid,
    output logic [TAG_W-1:0]  iss_rs_num,
    output logic [3:0]        iss_op,
    output logic [DATA_W-1:0] iss_pc,
    output logic [DATA_W-1:0] iss_val0,
    output logic [DATA_W-1:0] iss_val1,
    input  logic              ld_busy
);
    localparam int IW = $clog2(N);
    logic [N-1:0]      valid_q, valid_d, issued_q, issued_d;
    logic [3:0]        op_q [N], op_d [N];
    logic [DATA_W-1:0] pc_q [N], pc_d [N];
    src_t              s0_q [N], s0_d [N], s1_q [N], s1_d [N];
    logic [N-1:0]      older_q [N], older_d [N];
    logic              full_q, full_d, iss_valid_q, iss_valid_d;
    logic [TAG_W-1:0]  iss_rs_q, iss_rs_d;
    logic [3:0]        iss_op_q, iss_op_d;
    logic [DATA_W-1:0] iss_pc_q, iss_pc_d, iss_v0_q, iss_v0_d, iss_v1_q, iss_v1_d;
    logic [N-1:0]      ready, gnt, free_v, alloc_oh;
    logic              any_rdy, fire;
    logic [IW-1:0]     sel, slot;
    src_t              d0, d1;

    always_comb begin
        ready = '0;
        free_v = '0;
        for (int i = 0; i < N; i++) begin
            ready[i] = valid_q[i] && !issued_q[i] && s0_q[i].rdy && s1_q[i].rdy;
            free_v[i] = cdbA_valid && valid_q[i] && cdbA_rs_num == `RS_TAG(i);
        end
    end

    ld_rs_pick #(.N(N)) u_pick (
        .rdy_i  (ready),
        .older_i(older_q),
        .gnt_o  (gnt),
        .any_o  (any_rdy)
    );

    always_comb begin
        sel = '0;
        slot = '0;
        for (int i = N - 1; i >= 0; i--) begin
            sel = gnt[i] ? IW'(i) : sel;
            slot = !valid_q[i] ? IW'(i) : slot;
        end
    end

    always_comb begin
        fire = !ld_busy && !iss_valid_q && any_rdy;
        alloc_oh = '0;
        valid_d = '0;
        issued_d = '0;
        for (int i = 0; i < N; i++) alloc_oh[i] = disp_valid && !full_q && slot == IW'(i);
        d0 = capture(src_t'({disp_rdy0, disp_val0}), cdbA_valid, cdbA_rs_num, cdbA_res,
                     cdbB_valid, cdbB_rs_num, cdbB_res);
        d1 = capture(src_t'({disp_op == LD || disp_rdy1, disp_val1}), cdbA_valid, cdbA_rs_num,
                     cdbA_res, cdbB_valid, cdbB_rs_num, cdbB_res);
        for (int i = 0; i < N; i++) begin
            valid_d[i] = alloc_oh[i] || (valid_q[i] && !free_v[i]);
            issued_d[i] = !alloc_oh[i] && !free_v[i] && (issued_q[i] || (fire && gnt[i]));
            op_d[i] = alloc_oh[i] ? disp_op : op_q[i];
            pc_d[i] = alloc_oh[i] ? disp_pc : pc_q[i];
            s0_d[i] = alloc_oh[i] ? d0 : capture(s0_q[i], cdbA_valid, cdbA_rs_num, cdbA_res,
                                                 cdbB_valid, cdbB_rs_num, cdbB_res);
            s1_d[i] = alloc_oh[i] ? d1 : capture(s1_q[i], cdbA_valid, cdbA_rs_num, cdbA_res,
                                                 cdbB_valid, cdbB_rs_num, cdbB_res);
            older_d[i] = alloc_oh[i] ? valid_q & ~free_v : older_q[i] & ~free_v & ~alloc_oh;
        end
        full_d = &valid_d;
        iss_valid_d = fire;
        iss_rs_d = `RS_TAG(sel);
        iss_op_d = op_q[sel];
        iss_pc_d = pc_q[sel];
        iss_v0_d = s0_q[sel].val;
        iss_v1_d = s1_q[sel].val;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            issued_q <= '0;
            older_q <= '{default: '0};
            full_q <= 1'b0;
            iss_valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
            issued_q <= issued_d;
            older_q <= older_d;
            full_q <= full_d;
            iss_valid_q <= iss_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        op_q <= op_d;
        pc_q <= pc_d;
        s0_q <= s0_d;
        s1_q <= s1_d;
        iss_rs_q <= iss_rs_d;
        iss_op_q <= iss_op_d;
        iss_pc_q <= iss_pc_d;
        iss_v0_q <= iss_v0_d;
        iss_v1_q <= iss_v1_d;
    end

    always_ff @(posedge clk) begin
        assert (rst || !(disp_valid && full_q)) else $error("ld_rs: dispatch while full ignored");
    end

    assign disp_tag = `RS_TAG(slot);
    assign full = full_q;
    assign iss_valid = iss_valid_q;
    assign iss_rs_num = iss_rs_q;
    assign iss_op = iss_op_q;
    assign iss_pc = iss_pc_q;
    assign iss_val0 = iss_v0_q;
    assign iss_val1 = iss_v1_q;
endmodule
